// File: rtl/perf_dump_pkg.sv
// Shared types and constants for the performance-counter dump block.
// Optional trailing checksum byte is enabled by defining PERF_DUMP_CHECKSUM_EN.
package perf_dump_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam logic [BYTE_W-1:0] CSUM_INIT = 8'h00;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StCsum,
      StDone
   } state_e;

endpackage

// File: rtl/perf_sat_counter.sv
// One saturating event counter with a sticky overflow flag and synchronous clear.
module perf_sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o,
   output logic             overflow_o
);

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         count_o    <= '0;
         overflow_o <= 1'b0;
      end else if (inc_i) begin
         // An increment at the ceiling only records the loss; the count holds.
         if (&count_o) begin
            overflow_o <= 1'b1;
         end else begin
            count_o <= count_o + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/perf_counter_dump.sv
// Per-channel event counters with snapshot and byte-serial dump over a valid/ready link.
// Defining PERF_DUMP_CHECKSUM_EN appends an XOR checksum byte after the payload.
module perf_counter_dump
   import perf_dump_pkg::*;
#(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] event_i,
   input  logic              enable_i,
   input  logic              clear_i,
   input  logic              dump_i,
   output logic [7:0]        tx_data_o,
   output logic              tx_valid_o,
   input  logic              tx_ready_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [NUM_CH-1:0] overflow_o
);

   localparam int unsigned SNAP_W    = NUM_CH * CNT_W;
   localparam int unsigned NUM_BYTES = SNAP_W / BYTE_W;
   localparam int unsigned IDX_W     = $clog2(NUM_BYTES + 1);

   logic [SNAP_W-1:0] count_flat;
   logic [SNAP_W-1:0] shadow_q;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  idx_next;
   logic [BYTE_W-1:0] next_byte;
   logic              last_byte;
   state_e            state_q;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      perf_sat_counter #(
         .CNT_W(CNT_W)
      ) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .clear_i   (clear_i),
         .inc_i     (enable_i & event_i[k]),
         .count_o   (count_flat[k*CNT_W +: CNT_W]),
         .overflow_o(overflow_o[k])
      );
   end

   // Channel 0 occupies the low bits, so shifting by whole bytes walks ch0 LSB first.
   assign idx_next  = idx_q + IDX_W'(1);
   assign next_byte = BYTE_W'(shadow_q >> (BYTE_W * idx_next));
   assign last_byte = (idx_q == IDX_W'(NUM_BYTES - 1));

`ifdef PERF_DUMP_CHECKSUM_EN
   logic [BYTE_W-1:0] csum_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         shadow_q   <= '0;
         idx_q      <= '0;
         tx_data_o  <= '0;
         tx_valid_o <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
`ifdef PERF_DUMP_CHECKSUM_EN
         csum_q     <= CSUM_INIT;
`endif
      end else begin
         done_o <= 1'b0;
         case (state_q)
            StIdle: begin
               if (dump_i) begin
                  shadow_q   <= count_flat;
                  idx_q      <= '0;
                  tx_data_o  <= count_flat[BYTE_W-1:0];
                  tx_valid_o <= 1'b1;
                  busy_o     <= 1'b1;
                  state_q    <= StSend;
`ifdef PERF_DUMP_CHECKSUM_EN
                  csum_q     <= CSUM_INIT;
`endif
               end
            end
            StSend: begin
               if (tx_ready_i) begin
                  if (last_byte) begin
`ifdef PERF_DUMP_CHECKSUM_EN
                     // Fold in the final payload byte on its way out.
                     tx_data_o  <= csum_q ^ tx_data_o;
                     state_q    <= StCsum;
`else
                     tx_valid_o <= 1'b0;
                     busy_o     <= 1'b0;
                     done_o     <= 1'b1;
                     state_q    <= StDone;
`endif
                  end else begin
                     idx_q     <= idx_next;
                     tx_data_o <= next_byte;
`ifdef PERF_DUMP_CHECKSUM_EN
                     csum_q    <= csum_q ^ tx_data_o;
`endif
                  end
               end
            end
`ifdef PERF_DUMP_CHECKSUM_EN
            StCsum: begin
               if (tx_ready_i) begin
                  tx_valid_o <= 1'b0;
                  busy_o     <= 1'b0;
                  done_o     <= 1'b1;
                  state_q    <= StDone;
               end
            end
`endif
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_perf_counter_dump.sv
// Scoreboard bench for perf_counter_dump: a cycle-level model queues expected bytes,
// a negedge monitor checks handshakes, flags and status. Honours PERF_DUMP_CHECKSUM_EN.
module tb_perf_counter_dump;

   localparam int unsigned NUM_CH = 2;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned NBYTES = NUM_CH * CNT_W / 8;
   localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NUM_CH-1:0] event_i = '0;
   logic              enable_i = 1'b0;
   logic              clear_i = 1'b0;
   logic              dump_i = 1'b0;
   logic              tx_ready_i = 1'b0;
   logic [7:0]        tx_data_o;
   logic              tx_valid_o;
   logic              busy_o;
   logic              done_o;
   logic [NUM_CH-1:0] overflow_o;

   perf_counter_dump #(
      .NUM_CH(NUM_CH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .event_i   (event_i),
      .enable_i  (enable_i),
      .clear_i   (clear_i),
      .dump_i    (dump_i),
      .tx_data_o (tx_data_o),
      .tx_valid_o(tx_valid_o),
      .tx_ready_i(tx_ready_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   int unsigned n_pass = 0;
   int unsigned n_checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Reference model state
   longint unsigned cnt_m [NUM_CH];
   bit              ovf_m [NUM_CH];
   bit              busy_m = 1'b0;
   bit              done_m = 1'b0;
   bit              xfer_seen = 1'b0;
   logic [7:0]      exp_q [$];
   int              ready_mode = 0;

   // Model: counters are plain saturating integers; a dump is a list of bytes.
   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_CH; k++) begin
            cnt_m[k] = 0;
            ovf_m[k] = 1'b0;
         end
         busy_m = 1'b0;
         done_m = 1'b0;
         exp_q.delete();
      end else begin
         if (done_m) begin
            done_m = 1'b0;
         end else if (busy_m) begin
            if (xfer_seen && exp_q.size() == 0) begin
               busy_m = 1'b0;
               done_m = 1'b1;
            end
         end else if (dump_i) begin
            logic [7:0] sum;
            sum = 8'h00;
            for (int k = 0; k < NUM_CH; k++) begin
               for (int b = 0; b < CNT_W / 8; b++) begin
                  logic [7:0] by;
                  by = 8'((cnt_m[k] >> (8 * b)) & 64'hFF);
                  exp_q.push_back(by);
                  sum = sum ^ by;
               end
            end
`ifdef PERF_DUMP_CHECKSUM_EN
            exp_q.push_back(sum);
`endif
            busy_m = 1'b1;
         end
         for (int k = 0; k < NUM_CH; k++) begin
            if (clear_i) begin
               cnt_m[k] = 0;
               ovf_m[k] = 1'b0;
            end else if (enable_i && event_i[k]) begin
               if (cnt_m[k] == CNT_MAX) ovf_m[k] = 1'b1;
               else cnt_m[k] = cnt_m[k] + 1;
            end
         end
      end
   end

   // Monitor: everything sampled mid-cycle; a byte is consumed when valid and ready.
   always @(negedge clk) begin
      logic [NUM_CH-1:0] ovf_vec;
      for (int k = 0; k < NUM_CH; k++) ovf_vec[k] = ovf_m[k];
      chk("busy", {63'd0, busy_o}, {63'd0, busy_m});
      chk("done", {63'd0, done_o}, {63'd0, done_m});
      chk("tx_valid", {63'd0, tx_valid_o}, {63'd0, busy_m});
      chk("overflow", 64'(overflow_o), 64'(ovf_vec));
      xfer_seen = (tx_valid_o === 1'b1) && tx_ready_i;
      if (tx_valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("tx_byte_expected", 64'(exp_q.size()), 64'd1);
         end else begin
            chk("tx_data", 64'(tx_data_o), 64'(exp_q[0]));
            if (tx_ready_i) void'(exp_q.pop_front());
         end
      end
   end

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: tx_ready_i = 1'b1;
         1: tx_ready_i = ~tx_ready_i;
         default: tx_ready_i = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [NUM_CH-1:0] mask, input int n);
      enable_i = 1'b1;
      for (int i = 0; i < n; i++) begin
         event_i = mask;
         tick();
      end
      event_i = '0;
   endtask

   task automatic run_dump(input bit noisy);
      dump_i = 1'b1;
      tick();
      dump_i = 1'b0;
      for (int i = 0; i < 400 && (busy_m || done_m); i++) begin
         if (noisy) begin
            event_i  = NUM_CH'($urandom);
            enable_i = 1'($urandom_range(0, 1));
            clear_i  = ($urandom_range(0, 7) == 0);
            dump_i   = 1'($urandom_range(0, 1));
         end
         tick();
      end
      event_i = '0;
      clear_i = 1'b0;
      dump_i  = 1'b0;
      chk("dump_finished", {63'd0, (busy_m || done_m)}, 64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_tx_data", 64'(tx_data_o), 64'd0);
      chk("reset_tx_valid", {63'd0, tx_valid_o}, 64'd0);
      chk("reset_busy", {63'd0, busy_o}, 64'd0);
      chk("reset_overflow", 64'(overflow_o), 64'd0);

      // 5 events on ch0, 3 on ch1, always-ready link
      ready_mode = 0;
      pulse(2'b01, 5);
      pulse(2'b10, 3);
      run_dump(1'b0);

      // Multi-byte ordering with a stalling link
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      pulse(2'b11, 32'h56);
      pulse(2'b01, 32'h1234 - 32'h56);
      ready_mode = 1;
      run_dump(1'b0);

      // Random traffic, with clears, events and extra dump requests during each dump
      for (int it = 0; it < 12; it++) begin
         ready_mode = $urandom_range(0, 2);
         for (int c = 0; c < int'($urandom_range(20, 200)); c++) begin
            event_i  = NUM_CH'($urandom);
            enable_i = ($urandom_range(0, 3) != 0);
            clear_i  = ($urandom_range(0, 40) == 0);
            tick();
         end
         event_i = '0;
         clear_i = 1'b0;
         run_dump(1'b1);
      end

      // Saturation and sticky overflow, then clear
      ready_mode = 0;
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      pulse(2'b11, int'(CNT_MAX) + 3);
      chk("saturated_overflow", 64'(overflow_o), 64'd3);
      run_dump(1'b0);
      chk("overflow_sticky", 64'(overflow_o), 64'd3);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      chk("overflow_cleared", 64'(overflow_o), 64'd0);

      // Reset after the first payload byte has transferred
      pulse(2'b01, 7);
      pulse(2'b10, 9);
      dump_i = 1'b1;
      tick();
      dump_i = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() == 0; i++) tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_tx_valid", {63'd0, tx_valid_o}, 64'd0);
      chk("abort_busy", {63'd0, busy_o}, 64'd0);
      chk("abort_done", {63'd0, done_o}, 64'd0);
      repeat (5) tick();
      run_dump(1'b0);

      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/perf_counter_dump.md
PERF_COUNTER_DUMP -- requirements
Module: perf_counter_dump

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of event channels, range 1..32.
REQ-002 SHALL have parameter CNT_W, default 32: counter width in bits, a multiple of 8, range 8..64.
REQ-003 SHALL have port clk  input  1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port event_i  input  NUM_CH: per-channel increment pulse, one count per cycle high.
REQ-006 SHALL have port enable_i  input  1: counting enable.
REQ-007 SHALL have port clear_i  input  1: zero all counters and overflow flags.
REQ-008 SHALL have port dump_i  input  1: request a snapshot and serial dump.
REQ-009 SHALL have port tx_data_o  output  8: byte to the UART transmitter.
REQ-010 SHALL have port tx_valid_o  output  1: tx_data_o is valid.
REQ-011 SHALL have port tx_ready_i  input  1: the transmitter accepts the byte.
REQ-012 SHALL have port busy_o  output  1: a dump is in progress.
REQ-013 SHALL have port done_o  output  1: one-cycle pulse when a dump completes.
REQ-014 SHALL have port overflow_o  output  NUM_CH: sticky per-channel saturation flags.

Function
REQ-015 Counter k SHALL increment by 1 in each cycle where enable_i=1 and event_i[k]=1.
REQ-016 A counter SHALL saturate at 2^CNT_W-1; an increment attempted at saturation SHALL set overflow_o[k], which stays set until clear_i or rst.
REQ-017 clear_i SHALL have priority over an increment in the same cycle: the counter is 0 next cycle and the overflow flag is 0.
REQ-018 The FSM SHALL have the states IDLE, SEND, CSUM and DONE.
REQ-019 In IDLE, dump_i=1 SHALL copy all counters (pre-increment values of that cycle) into a shadow register and move to SEND; busy_o=1 and tx_valid_o=1 SHALL appear in the next cycle.
REQ-020 In SEND, bytes SHALL be sent channel 0 first, each channel least-significant byte first, for NUM_CH*CNT_W/8 bytes in total.
REQ-021 A byte SHALL transfer only in a cycle with tx_valid_o=1 and tx_ready_i=1; tx_data_o SHALL hold stable while tx_valid_o=1 and tx_ready_i=0.
REQ-022 After the last payload byte transfers, the FSM SHALL go to CSUM if the checksum feature is compiled in, otherwise to DONE.
REQ-023 DONE SHALL last one cycle with done_o=1 and tx_valid_o=0, then return to IDLE; busy_o SHALL be 0 in DONE.
REQ-024 dump_i SHALL be ignored while busy_o=1 or while the FSM is in DONE.
REQ-025 Counting and clear_i SHALL continue during a dump and SHALL NOT alter the shadow being sent.
REQ-026 The byte index SHALL be wide enough for NUM_CH*CNT_W/8 and SHALL be reset to 0 on entry to SEND.

Reset
REQ-027 rst SHALL return the FSM to IDLE, abort any dump in progress, and set all counters, the shadow, overflow_o, tx_data_o, tx_valid_o, busy_o and done_o to 0.
REQ-028 rst SHALL have priority over clear_i, dump_i and events in the same cycle.

Configuration
REQ-029 With macro PERF_DUMP_CHECKSUM_EN defined, the CSUM state SHALL send one extra byte equal to the XOR of all payload bytes, starting from 0x00, under the REQ-021 handshake.
REQ-030 Without PERF_DUMP_CHECKSUM_EN, CSUM SHALL be unreachable and no checksum logic SHALL be synthesised.

Structure
REQ-031 The package perf_dump_pkg SHALL hold the FSM state enum, BYTE_W=8, and CSUM_INIT=8'h00.
REQ-032 Each channel SHALL be one instance of the sub-module perf_sat_counter (increment, saturate, sticky flag, clear), generated NUM_CH times.

Verification
REQ-033 NUM_CH=2, CNT_W=8: 5 pulses on ch0 and 3 on ch1, then dump with tx_ready_i=1 -> bytes 0x05, 0x03, done_o one cycle later.
REQ-034 CNT_W=8: 300 pulses on ch0 -> counter 0xFF, overflow_o[0]=1; then clear_i -> counter 0, overflow_o[0]=0.
REQ-035 CNT_W=32, ch0=0x12345678, tx_ready_i toggling every other cycle -> bytes 0x78, 0x56, 0x34, 0x12, with tx_data_o stable while stalled.
REQ-036 dump_i, clear_i and events asserted mid-dump -> the transmitted values equal the snapshot, and the second dump_i is ignored.
REQ-037 With PERF_DUMP_CHECKSUM_EN, payload 0x05, 0x03 -> a trailing byte of 0x06.
REQ-038 rst asserted after byte 1 of 4 -> next cycle tx_valid_o=0, busy_o=0, all counters 0, and done_o never pulses.
